mdio_master_gen: RTL

// - Parametrised MDIO management master. Serialises a 32-bit management frame onto MDIO,

---
 rtl/mdio_master_gen.sv | 188 ++++++++++++++++++
 1 files changed

// File: rtl/mdio_master_gen.sv
// +--------------------------------------------------------------------------+
// | mdio_master_gen: MDIO management master with divided MDC and preamble.   |
// | Optional clause-45 framing: define MDIO_C45_EN.  Rev 1.0                 |
// +--------------------------------------------------------------------------+
`default_nettype none

module mdio_master_gen #(
  parameter int CLK_DIV       = 4,
  parameter int PREAMBLE_BITS = 32
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        mdio_start,
  input  logic [31:0] t_data,
  input  logic        mdio_in,
  output logic [15:0] rd_data,
  output logic        data_rdy,
  output logic        busy,
  output logic        mdc,
  output logic        mdio_oe,
  output logic        mdio_out
);

  localparam int DW = $clog2(CLK_DIV);
  localparam logic [DW-1:0] c_div_last = DW'(CLK_DIV - 1);
  localparam logic [DW-1:0] c_div_half = DW'(CLK_DIV / 2);
  localparam logic [DW-1:0] c_div_fall = DW'(CLK_DIV / 2 - 1);
  localparam logic [5:0]    c_pre_last = (PREAMBLE_BITS > 0) ? 6'(PREAMBLE_BITS - 1) : 6'd0;

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_WAIT_FALL = 3'd1,
    S_PREAMBLE  = 3'd2,
    S_HEADER    = 3'd3,
    S_WDATA     = 3'd4,
    S_TURN      = 3'd5,
    S_RDATA     = 3'd6,
    S_DONE      = 3'd7
  } state_t;

  localparam state_t c_first = (PREAMBLE_BITS > 0) ? S_PREAMBLE : S_HEADER;

  state_t        r_state, w_state_nxt, w_cur_state;
  logic [5:0]    r_cnt, w_cnt_nxt, w_cur_cnt;
  logic [DW-1:0] r_div, w_div_nxt;
  logic          r_mdc, r_out, r_oe, r_is_read, r_rdy;
  logic [31:0]   r_frame, w_frame_in;
  logic [15:0]   r_shift, r_rd_data;
  logic          w_fall, w_rise, w_accept, w_is_read_in, w_sample, w_done;
  logic          w_out_nxt, w_oe_nxt, w_phase_last;

  assign w_div_nxt = (r_div == c_div_last) ? '0 : r_div + 1'b1;
  assign w_fall    = (r_div == c_div_fall);
  assign w_rise    = (r_div == c_div_last);
  assign w_accept  = (r_state == S_IDLE) && mdio_start;

`ifdef MDIO_C45_EN
  assign w_frame_in   = t_data;
  assign w_is_read_in = (t_data[31:30] == 2'b00) ? t_data[29] : (t_data[29:28] == 2'b10);
`else
  logic w_unused_st;
  assign w_unused_st  = ^t_data[31:30];
  assign w_frame_in   = {2'b01, t_data[29:0]};
  assign w_is_read_in = (t_data[29:28] == 2'b10);
`endif

  // Read bit k is driven after the k-th RDATA fall and sampled on the following rise.
  assign w_sample = w_rise && (((r_state == S_RDATA) && (r_cnt != 6'd0)) ||
                               ((r_state == S_DONE) && r_is_read));

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state <= S_IDLE;
      r_cnt   <= 6'd0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  always_comb begin
    w_state_nxt  = r_state;
    w_cnt_nxt    = r_cnt;
    w_out_nxt    = r_out;
    w_oe_nxt     = r_oe;
    w_done       = 1'b0;
    // WAIT_FALL behaves as bit 0 of the first phase once the fall arrives.
    w_cur_state  = (r_state == S_WAIT_FALL) ? c_first : r_state;
    w_cur_cnt    = (r_state == S_WAIT_FALL) ? 6'd0 : r_cnt;
    w_phase_last = 1'b0;
    case (w_cur_state)
      S_PREAMBLE: w_phase_last = (w_cur_cnt == c_pre_last);
      S_HEADER:   w_phase_last = (w_cur_cnt == 6'd13);
      S_WDATA:    w_phase_last = (w_cur_cnt == 6'd17);
      S_TURN:     w_phase_last = (w_cur_cnt == 6'd1);
      S_RDATA:    w_phase_last = (w_cur_cnt == 6'd15);
      default:    w_phase_last = 1'b0;
    endcase
    case (r_state)
      S_IDLE: begin
        if (mdio_start) begin
          w_state_nxt = S_WAIT_FALL;
          w_cnt_nxt   = 6'd0;
        end
      end
      S_DONE: begin
        if (w_fall) begin
          w_state_nxt = S_IDLE;
          w_out_nxt   = 1'b0;
          w_oe_nxt    = 1'b0;
          w_done      = 1'b1;
        end
      end
      default: begin
        if (w_fall) begin
          w_cnt_nxt = w_phase_last ? 6'd0 : w_cur_cnt + 6'd1;
          case (w_cur_state)
            S_PREAMBLE: begin
              w_out_nxt   = 1'b1;
              w_oe_nxt    = 1'b1;
              w_state_nxt = w_phase_last ? S_HEADER : S_PREAMBLE;
            end
            S_HEADER: begin
              w_out_nxt   = r_frame[5'd31 - w_cur_cnt[4:0]];
              w_oe_nxt    = 1'b1;
              w_state_nxt = w_phase_last ? (r_is_read ? S_TURN : S_WDATA) : S_HEADER;
            end
            S_WDATA: begin
              w_out_nxt   = r_frame[5'd17 - w_cur_cnt[4:0]];
              w_oe_nxt    = 1'b1;
              w_state_nxt = w_phase_last ? S_DONE : S_WDATA;
            end
            S_TURN: begin
              w_out_nxt   = 1'b0;
              w_oe_nxt    = 1'b0;
              w_state_nxt = w_phase_last ? S_RDATA : S_TURN;
            end
            S_RDATA: begin
              w_out_nxt   = 1'b0;
              w_oe_nxt    = 1'b0;
              w_state_nxt = w_phase_last ? S_DONE : S_RDATA;
            end
            default: w_state_nxt = S_IDLE;
          endcase
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_div     <= '0;
      r_mdc     <= 1'b0;
      r_out     <= 1'b0;
      r_oe      <= 1'b0;
      r_frame   <= 32'd0;
      r_is_read <= 1'b0;
      r_shift   <= 16'd0;
      r_rd_data <= 16'd0;
      r_rdy     <= 1'b0;
    end else begin
      r_div <= w_div_nxt;
      r_mdc <= (w_div_nxt < c_div_half);
      r_out <= w_out_nxt;
      r_oe  <= w_oe_nxt;
      r_rdy <= 1'b0;
      if (w_accept) begin
        r_frame   <= w_frame_in;
        r_is_read <= w_is_read_in;
      end
      if (w_sample) r_shift <= {r_shift[14:0], mdio_in};
      if (w_done && r_is_read) begin
        r_rd_data <= r_shift;
        r_rdy     <= 1'b1;
      end
    end
  end

  assign busy     = (r_state != S_IDLE);
  assign mdc      = r_mdc;
  assign mdio_oe  = r_oe;
  assign mdio_out = r_out;
  assign rd_data  = r_rd_data;
  assign data_rdy = r_rdy;

endmodule

`default_nettype wire
